// File: rtl/prog_loader.sv
// Byte-stream program loader: parses a framed image (count, big-endian words, checksum),
// writes words to instruction memory and releases the core only after a clean load.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64,
  parameter int          TIMEOUT   = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        cpu_enable,
  output logic        busy,
  output logic        err
);

  localparam int          TW   = $clog2(TIMEOUT + 1);
  localparam logic [15:0] MAXW = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_WRITE, S_CHK, S_RUN, S_ERR
  } state_t;

  state_t          state, state_n;
  logic [7:0]      cnt_hi;
  logic [15:0]     n_words;
  logic [15:0]     idx;
  logic [1:0]      bcnt;
  logic [7:0]      sum;
  logic [31:0]     word;
  logic [31:0]     addr_q;
  logic [TW-1:0]   idle_cnt;

  logic        xfer;
  logic        can_start;
  logic        timeout_hit;
  logic [15:0] n_hdr;
  logic [15:0] idx_inc;

  assign byte_ready  = (state == S_HDR_HI) || (state == S_HDR_LO) ||
                       (state == S_DATA)   || (state == S_CHK);
  assign xfer        = byte_valid && byte_ready;
  assign can_start   = (state == S_IDLE) || (state == S_RUN) || (state == S_ERR);
  assign timeout_hit = byte_ready && !xfer && (idle_cnt == TW'(TIMEOUT - 1));
  assign n_hdr       = {cnt_hi, byte_data};
  assign idx_inc     = idx + 16'd1;

  assign imem_we    = (state == S_WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = word;
  assign cpu_reset  = (state != S_RUN);
  assign cpu_enable = (state == S_RUN);
  assign busy       = byte_ready || (state == S_WRITE);
  assign err        = (state == S_ERR);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_RUN, S_ERR: if (start) state_n = S_HDR_HI;
      S_HDR_HI: begin
        if (timeout_hit) state_n = S_ERR;
        else if (xfer)   state_n = S_HDR_LO;
      end
      S_HDR_LO: begin
        if (timeout_hit) state_n = S_ERR;
        else if (xfer) begin
          if (n_hdr == 16'd0)    state_n = S_CHK;
          else if (n_hdr > MAXW) state_n = S_ERR;
          else                   state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (timeout_hit)              state_n = S_ERR;
        else if (xfer && bcnt == 2'd3) state_n = S_WRITE;
      end
      S_WRITE: state_n = (idx_inc == n_words) ? S_CHK : S_DATA;
      S_CHK: begin
        if (timeout_hit) state_n = S_ERR;
        else if (xfer)   state_n = (byte_data == sum) ? S_RUN : S_ERR;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt_hi   <= '0;
      n_words  <= '0;
      idx      <= '0;
      bcnt     <= '0;
      sum      <= '0;
      word     <= '0;
      addr_q   <= BASE_ADDR;
      idle_cnt <= '0;
    end else begin
      state <= state_n;
      if (can_start && start) begin
        sum      <= '0;
        idx      <= '0;
        bcnt     <= '0;
        idle_cnt <= '0;
      end else begin
        if (xfer) begin
          idle_cnt <= '0;
          // The checksum byte itself is not part of the sum it is compared against
          if (state != S_CHK) sum <= sum + byte_data;
        end else if (byte_ready) begin
          idle_cnt <= idle_cnt + 1'b1;
        end
        if (xfer && state == S_HDR_HI) cnt_hi  <= byte_data;
        if (xfer && state == S_HDR_LO) n_words <= n_hdr;
        if (xfer && state == S_DATA) begin
          word <= {word[23:0], byte_data};
          bcnt <= bcnt + 2'd1;
          if (bcnt == 2'd3) addr_q <= BASE_ADDR + {14'd0, idx, 2'b00};
        end
        if (state == S_WRITE) idx <= idx_inc;
      end
    end
  end

endmodule
